// File: rtl/cdtimer_pkg.sv
// Shared types for the countdown timer bank: command opcodes, channel state and reload mode.
package cdtimer_pkg;

    typedef enum logic [1:0] {
        LOAD_ONE = 2'd0,
        LOAD_PER = 2'd1,
        STOP     = 2'd2,
        ACK      = 2'd3
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        ONE = 1'b0,
        PER = 1'b1
    } mode_t;

    localparam int PHASE_W = 16;

    function automatic logic is_load(input op_t op);
        return (op == LOAD_ONE) || (op == LOAD_PER);
    endfunction

endpackage

// File: rtl/cdtimer_chan.sv
// One countdown channel: prescale phase counter, down counter with optional auto-reload,
// and a sticky timeout flag.
module cdtimer_chan
    import cdtimer_pkg::*;
#(
    parameter int PERIOD = 27000,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             load_per,
    input  logic             stop,
    input  logic             ack,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] counter,
    output logic             timeout,
    output logic             running
);

    localparam logic [PHASE_W:0] PERIOD_T = (PHASE_W + 1)'(PERIOD);

    state_t             state;
    mode_t              mode;
    logic [WIDTH-1:0]   reload;
    logic [PHASE_W-1:0] phase;
    logic               tick;
    logic               expire;

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - WIDTH'(1);
    endfunction

    // PERIOD of 0 or 1 makes every clock a tick, since phase+1 >= PERIOD always holds.
    assign tick   = ({1'b0, phase} + (PHASE_W + 1)'(1)) >= PERIOD_T;
    assign expire = (state == RUN) && tick && (counter == WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= ONE;
            counter <= '0;
            reload  <= '0;
            phase   <= '0;
            timeout <= 1'b0;
        end else if (load) begin
            timeout <= 1'b0;
            phase   <= '0;
            if (data != '0) begin
                counter <= data;
                reload  <= data;
                mode    <= load_per ? PER : ONE;
                state   <= RUN;
            end else begin
                counter <= '0;
                state   <= IDLE;
            end
        end else begin
            // Expiry outranks both ACK and STOP in the same cycle.
            if (expire) begin
                timeout <= 1'b1;
            end else if (ack) begin
                timeout <= 1'b0;
            end

            if (state == RUN) begin
                if (expire) begin
                    phase <= '0;
                    if (mode == PER) begin
                        counter <= reload;
                    end else begin
                        counter <= '0;
                        state   <= IDLE;
                    end
                end else if (stop) begin
                    phase <= '0;
                    state <= IDLE;
                end else if (tick) begin
                    phase   <= '0;
                    counter <= sat_dec(counter);
                end else begin
                    phase <= phase + PHASE_W'(1);
                end
            end else if (stop) begin
                phase <= '0;
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: rtl/cdtimer_bank.sv
// Bank of NCH countdown timers behind a single command port, with a registered
// interrupt request that is the OR of all sticky timeout flags.
module cdtimer_bank
    import cdtimer_pkg::*;
#(
    parameter  int PERIOD = 27000,
    parameter  int WIDTH  = 16,
    parameter  int NCH    = 4,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [CHW-1:0]       cmd_ch,
    input  logic [1:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_data,
    output logic [NCH*WIDTH-1:0] counter,
    output logic [NCH-1:0]       timeout,
    output logic [NCH-1:0]       running,
    output logic                 irq
);

    op_t            op;
    logic [NCH-1:0] sel;
    logic [NCH-1:0] ld;
    logic [NCH-1:0] ldp;
    logic [NCH-1:0] stp;
    logic [NCH-1:0] ak;

    assign op = op_t'(cmd_op);

    // Channel indices at or above NCH match no strobe, so such commands fall away.
    always_comb begin
        sel = '0;
        ld  = '0;
        ldp = '0;
        stp = '0;
        ak  = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i] = cmd_valid && (cmd_ch == CHW'(i));
            ld[i]  = sel[i] && is_load(op);
            ldp[i] = sel[i] && (op == LOAD_PER);
            stp[i] = sel[i] && (op == STOP);
            ak[i]  = sel[i] && (op == ACK);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        cdtimer_chan #(
            .PERIOD (PERIOD),
            .WIDTH  (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ld[g]),
            .load_per (ldp[g]),
            .stop     (stp[g]),
            .ack      (ak[g]),
            .data     (cmd_data),
            .counter  (counter[g*WIDTH +: WIDTH]),
            .timeout  (timeout[g]),
            .running  (running[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |timeout;
        end
    end

endmodule

// File: tb/tb_cdtimer_bank.sv
// Bench for cdtimer_bank: directed table, hand-written corner sequences and a randomized
// run compared against a closed-form elapsed-time model of each channel.
module tb_cdtimer_bank;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_ch = '0;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_data = '0;
    logic [63:0] counter;
    logic [3:0]  timeout;
    logic [3:0]  running;
    logic        irq;

    logic        b_valid = 1'b0;
    logic [1:0]  b_ch = '0;
    logic [1:0]  b_op = '0;
    logic [7:0]  b_data = '0;
    logic [23:0] b_counter;
    logic [2:0]  b_timeout;
    logic [2:0]  b_running;
    logic        b_irq;

    cdtimer_bank #(.PERIOD(P), .WIDTH(16), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .counter(counter),
        .timeout(timeout), .running(running), .irq(irq)
    );

    cdtimer_bank #(.PERIOD(0), .WIDTH(8), .NCH(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ch(b_ch),
        .cmd_op(b_op), .cmd_data(b_data), .counter(b_counter),
        .timeout(b_timeout), .running(b_running), .irq(b_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model: per channel, the load instant and value; counts are derived from
    // elapsed clocks rather than stepped.
    int m_act[4];
    int m_per[4];
    int m_load[4];
    int m_data[4];
    int m_frozen[4];
    int m_to[4];
    int m_irq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int mcount(input int i, input int c);
        int e, k;
        if (m_act[i] == 0) return m_frozen[i];
        e = c - m_load[i];
        k = e / P;
        if (m_per[i] != 0) return m_data[i] - (k % m_data[i]);
        return (m_data[i] > k) ? m_data[i] - k : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_per[i] = 0; m_load[i] = 0;
            m_data[i] = 0; m_frozen[i] = 0; m_to[i] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step(input bit v, input int ch, input int op, input int d);
        int e;
        bit expire;
        m_irq = 0;
        for (int i = 0; i < 4; i++) if (m_to[i] != 0) m_irq = 1;
        for (int i = 0; i < 4; i++) begin
            e = cyc_n - m_load[i];
            if (m_act[i] == 0)       expire = 0;
            else if (m_per[i] != 0)  expire = (e > 0) && (e % (m_data[i] * P) == 0);
            else                     expire = (e == m_data[i] * P);
            if (v && ch == i && (op == 0 || op == 1)) begin
                m_to[i] = 0;
                if (d != 0) begin
                    m_act[i] = 1; m_load[i] = cyc_n; m_data[i] = d; m_per[i] = (op == 1);
                end else begin
                    m_act[i] = 0; m_frozen[i] = 0;
                end
            end else begin
                if (expire) begin
                    m_to[i] = 1;
                    if (m_per[i] == 0) begin m_act[i] = 0; m_frozen[i] = 0; end
                end
                if (v && ch == i && op == 3 && !expire) m_to[i] = 0;
                if (v && ch == i && op == 2 && !expire && m_act[i] != 0) begin
                    m_frozen[i] = mcount(i, cyc_n - 1);
                    m_act[i] = 0;
                end
            end
        end
    endtask

    task automatic model_cmp(input string tag);
        logic [63:0] ec;
        logic [3:0]  et, er;
        for (int i = 0; i < 4; i++) begin
            ec[i*16 +: 16] = 16'(mcount(i, cyc_n));
            et[i] = (m_to[i] != 0);
            er[i] = (m_act[i] != 0);
        end
        chk({tag, ".counter"}, counter, ec);
        chk({tag, ".timeout"}, 64'(timeout), 64'(et));
        chk({tag, ".running"}, 64'(running), 64'(er));
        chk({tag, ".irq"}, 64'(irq), 64'(m_irq));
    endtask

    task automatic cyc(input bit v, input int ch, input int op, input int d);
        cmd_valid = v;
        cmd_ch    = 2'(ch);
        cmd_op    = 2'(op);
        cmd_data  = 16'(d);
        @(posedge clk);
        cyc_n++;
        model_step(v, ch, op, d);
        #1;
        cmd_valid = 1'b0;
        b_valid   = 1'b0;
    endtask

    typedef struct {
        bit v;
        int ch;
        int op;
        int d;
        int ecnt;
        bit eto;
        bit erun;
        bit eirq;
    } vec_t;

    vec_t tbl[16];
    int   exp_t[4];
    int   dv[4];
    logic [3:0] ev;

    initial begin
        // One-shot ch0 data=3: count steps every 4 clocks, expires at +12, irq one clock later,
        // ACK at +14 clears the flag and irq drops at +15.
        for (int k = 0; k < 16; k++) begin
            tbl[k] = '{0, 0, 0, 0,
                       (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0,
                       (k == 12 || k == 13), (k < 12), (k == 13 || k == 14)};
        end
        tbl[0].v = 1; tbl[0].d = 3;
        tbl[14].v = 1; tbl[14].op = 3;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.counter", counter, 64'd0);
        chk("reset.timeout", 64'(timeout), 64'd0);
        chk("reset.running", 64'(running), 64'd0);
        chk("reset.irq", 64'(irq), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].v, tbl[k].ch, tbl[k].op, tbl[k].d);
            chk($sformatf("one.cnt%0d", k), 64'(counter[15:0]), 64'(tbl[k].ecnt));
            chk($sformatf("one.to%0d", k), 64'(timeout[0]), 64'(tbl[k].eto));
            chk($sformatf("one.run%0d", k), 64'(running[0]), 64'(tbl[k].erun));
            chk($sformatf("one.irq%0d", k), 64'(irq), 64'(tbl[k].eirq));
        end

        // Periodic ch1 data=2: expiry every 8 clocks, ACK at +10 clears, ACK at +16 loses.
        cyc(1, 1, 1, 2);
        for (int k = 1; k <= 16; k++) begin
            cyc((k == 10 || k == 16), 1, 3, 0);
            if (k == 7)  chk("per.to7", 64'(timeout[1]), 64'd0);
            if (k == 7)  chk("per.cnt7", 64'(counter[31:16]), 64'd1);
            if (k == 8)  chk("per.to8", 64'(timeout[1]), 64'd1);
            if (k == 8)  chk("per.cnt8", 64'(counter[31:16]), 64'd2);
            if (k == 10) chk("per.ack10", 64'(timeout[1]), 64'd0);
            if (k == 16) chk("per.to16", 64'(timeout[1]), 64'd1);
            if (k == 16) chk("per.run16", 64'(running[1]), 64'd1);
        end
        cyc(1, 1, 2, 0);
        cyc(1, 1, 3, 0);
        chk("per.stopped", 64'({running[1], timeout[1]}), 64'd0);

        // STOP freezes ch2 at 8 with no timeout; a fresh LOAD_ONE 1 expires 4 clocks later.
        cyc(1, 2, 0, 10);
        for (int k = 1; k <= 9; k++) cyc((k == 9), 2, 2, 0);
        repeat (20) cyc(0, 0, 0, 0);
        chk("stop.cnt", 64'(counter[47:32]), 64'd8);
        chk("stop.to", 64'(timeout[2]), 64'd0);
        chk("stop.run", 64'(running[2]), 64'd0);
        cyc(1, 2, 0, 1);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("reload.to3", 64'(timeout[2]), 64'd0);
        cyc(0, 0, 0, 0);
        chk("reload.to4", 64'(timeout[2]), 64'd1);
        cyc(1, 2, 3, 0);

        // Zero load goes straight to IDLE and never times out.
        cyc(1, 3, 0, 0);
        chk("zero.run", 64'(running[3]), 64'd0);
        repeat (8) cyc(0, 0, 0, 0);
        chk("zero.to", 64'(timeout[3]), 64'd0);
        chk("zero.cnt", 64'(counter[63:48]), 64'd0);

        // Four channels loaded on consecutive clocks expire at their own instants.
        dv    = '{1, 2, 3, 1};
        exp_t = '{4, 9, 14, 7};
        for (int k = 0; k < 16; k++) begin
            if (k < 4) cyc(1, k, 0, dv[k]);
            else       cyc(0, 0, 0, 0);
            for (int i = 0; i < 4; i++) ev[i] = (k >= exp_t[i]);
            chk($sformatf("four.to%0d", k), 64'(timeout), 64'(ev));
        end
        for (int i = 0; i < 4; i++) cyc(1, i, 3, 0);

        // PERIOD=0 build: data=1 times out one clock after the load; channel 3 of 3 is ignored.
        b_valid = 1'b1; b_ch = 2'd0; b_op = 2'd0; b_data = 8'd1;
        cyc(0, 0, 0, 0);
        chk("p0.cnt0", 64'(b_counter), 64'd1);
        chk("p0.to0", 64'(b_timeout), 64'd0);
        chk("p0.run0", 64'(b_running), 64'd1);
        cyc(0, 0, 0, 0);
        chk("p0.to1", 64'(b_timeout), 64'd1);
        chk("p0.cnt1", 64'(b_counter), 64'd0);
        chk("p0.run1", 64'(b_running), 64'd0);
        b_valid = 1'b1; b_ch = 2'd3; b_op = 2'd0; b_data = 8'd5;
        cyc(0, 0, 0, 0);
        b_valid = 1'b1; b_ch = 2'd3; b_op = 2'd3; b_data = 8'd0;
        cyc(0, 0, 0, 0);
        chk("oob.cnt", 64'(b_counter), 64'd0);
        chk("oob.run", 64'(b_running), 64'd0);
        chk("oob.to", 64'(b_timeout), 64'd1);
        chk("oob.irq", 64'(b_irq), 64'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 6));
            model_cmp($sformatf("rnd%0d", n));
        end

        // Asynchronous reset mid-run with ch0 at 5 and a flag pending on ch1.
        cyc(1, 1, 0, 1);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 5);
        cyc(0, 0, 0, 0);
        chk("pre.cnt0", 64'(counter[15:0]), 64'd5);
        chk("pre.irq", 64'(irq), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.counter", counter, 64'd0);
        chk("arst.timeout", 64'(timeout), 64'd0);
        chk("arst.running", 64'(running), 64'd0);
        chk("arst.irq", 64'(irq), 64'd0);
        chk("arst.b", 64'({b_counter, b_timeout, b_running, b_irq}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) cyc(0, 0, 0, 0);
        chk("post.run0", 64'(running[0]), 64'd0);
        chk("post.cnt0", 64'(counter[15:0]), 64'd0);
        model_cmp("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
